obstacle_spawner: RTL

Consumes the pseudo-random byte from the LFSR and turns it into the Dino game's obstacle stream. It owns the `lfsr_en` enable and schedules spawns with a random gap and a random obstacle type, in two slots. It moves both slots leftward by `speed` pixels on every `game_tick`, and retires obstacles that leave the screen with a score pulse. It sits between the LFSR and the collision/renderer logic.

---
 rtl/dino_pkg.sv | 24 ++
 rtl/obstacle_slot.sv | 48 ++++
 rtl/obstacle_spawner.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dino_pkg.sv
// Shared Dino game definitions: obstacle types, spawner FSM states and the
// spawn-gap counter width.
package dino_pkg;

   localparam int GAP_W = 8;

   localparam logic [1:0] OBS_CACTUS_S0 = 2'd0;
   localparam logic [1:0] OBS_CACTUS_S1 = 2'd1;
   localparam logic [1:0] OBS_CACTUS_L  = 2'd2;
   localparam logic [1:0] OBS_BIRD      = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   // Gap reload after a spawn: minimum gap plus a 0..63 random extension.
   function automatic logic [GAP_W-1:0] gap_reload(input logic [GAP_W-1:0] min_gap,
                                                   input logic [5:0]       r);
      return min_gap + {2'b00, r};
   endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: holds valid/x/type, scrolls left on move and retires
// itself once it would cross the left screen edge.
module obstacle_slot
   import dino_pkg::*;
#(
   parameter int X_WIDTH = 10,
   parameter int SPAWN_X = 639
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               move,
   input  logic [2:0]         speed,
   input  logic               load,
   input  logic [1:0]         load_type,
   output logic               valid,
   output logic [X_WIDTH-1:0] x,
   output logic [1:0]         obs_type,
   output logic               retire
);

   logic [X_WIDTH:0] x_next;

   // The borrow bit of the widened subtraction is exactly x < speed.
   assign x_next = {1'b0, x} - {{(X_WIDTH-2){1'b0}}, speed};
   assign retire = move && valid && x_next[X_WIDTH];

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         valid    <= 1'b0;
         x        <= '0;
         obs_type <= OBS_CACTUS_S0;
      end else if (load) begin
         valid    <= 1'b1;
         x        <= X_WIDTH'(SPAWN_X);
         obs_type <= load_type;
      end else if (move && valid) begin
         if (x_next[X_WIDTH]) begin
            valid    <= 1'b0;
            x        <= '0;
            obs_type <= OBS_CACTUS_S0;
         end else begin
            x <= x_next[X_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/obstacle_spawner.sv
// Dino obstacle spawner: game FSM, random spawn gap, two-slot allocation and
// the score pulse for obstacles leaving the screen.
module obstacle_spawner
   import dino_pkg::*;
#(
   parameter int NUM_BITS = 8,
   parameter int X_WIDTH  = 10,
   parameter int SPAWN_X  = 639,
   parameter int MIN_GAP  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                game_tick,
   input  logic                start,
   input  logic                crash,
   input  logic [2:0]          speed,
   input  logic [NUM_BITS-1:0] rnd,
   output logic                lfsr_en,
   output logic                obs0_valid,
   output logic                obs1_valid,
   output logic [X_WIDTH-1:0]  obs0_x,
   output logic [X_WIDTH-1:0]  obs1_x,
   output logic [1:0]          obs0_type,
   output logic [1:0]          obs1_type,
   output logic                obs_passed,
   output logic                halted
);

   state_t           state;
   logic [GAP_W-1:0] gap_cnt;
   logic [7:0]       rnd_byte;
   logic             tick;
   logic             gap_zero;
   logic             load0;
   logic             load1;
   logic             clear;
   logic             ret0;
   logic             ret1;

   assign rnd_byte = rnd[7:0];
   // A crash in the same cycle as a tick wins: the field does not advance.
   assign tick     = (state == RUN) && game_tick && !crash;
   assign gap_zero = (gap_cnt == '0);
   // Allocation looks at occupancy before this tick's retire.
   assign load0    = tick && gap_zero && !obs0_valid;
   assign load1    = tick && gap_zero && obs0_valid && !obs1_valid;
   assign clear    = (state == HALT) && start;

   obstacle_slot #(.X_WIDTH(X_WIDTH), .SPAWN_X(SPAWN_X)) u_slot0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .move      (tick),
      .speed     (speed),
      .load      (load0),
      .load_type (rnd_byte[7:6]),
      .valid     (obs0_valid),
      .x         (obs0_x),
      .obs_type  (obs0_type),
      .retire    (ret0)
   );

   obstacle_slot #(.X_WIDTH(X_WIDTH), .SPAWN_X(SPAWN_X)) u_slot1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .move      (tick),
      .speed     (speed),
      .load      (load1),
      .load_type (rnd_byte[7:6]),
      .valid     (obs1_valid),
      .x         (obs1_x),
      .obs_type  (obs1_type),
      .retire    (ret1)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         gap_cnt    <= GAP_W'(MIN_GAP);
         lfsr_en    <= 1'b0;
         halted     <= 1'b0;
         obs_passed <= 1'b0;
      end else begin
         obs_passed <= tick && (ret0 || ret1);
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  lfsr_en <= 1'b1;
               end
            end
            RUN: begin
               if (crash) begin
                  state   <= HALT;
                  lfsr_en <= 1'b0;
                  halted  <= 1'b1;
               end else if (game_tick) begin
                  // With both slots busy the counter simply stays at zero.
                  if (!gap_zero)
                     gap_cnt <= gap_cnt - GAP_W'(1);
                  else if (load0 || load1)
                     gap_cnt <= gap_reload(GAP_W'(MIN_GAP), rnd_byte[5:0]);
               end
            end
            HALT: begin
               if (start) begin
                  state   <= RUN;
                  lfsr_en <= 1'b1;
                  halted  <= 1'b0;
                  gap_cnt <= GAP_W'(MIN_GAP);
               end
            end
            default: begin
               state   <= IDLE;
               lfsr_en <= 1'b0;
               halted  <= 1'b0;
               gap_cnt <= GAP_W'(MIN_GAP);
            end
         endcase
      end
   end

endmodule
